// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised oversampling UART receiver
// Optional RX_MAJORITY_VOTE_EN: 2-of-3 vote around each sample point, one cycle later.
module uart_rx_param #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 data_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 character_received,
    output logic                 framing_error,
    output logic                 parity_error,
    output logic                 busy
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

    state_t                state, state_next;
    logic [TW-1:0]         tick;
    logic [3:0]            bit_cnt;
    logic [DATA_BITS-1:0]  shift;
    logic                  par, fe_acc, pe_acc;
    logic                  rx_bit, start_seen, sample, par_err_now;

`ifdef RX_MAJORITY_VOTE_EN
    logic [1:0] hist;
    always_ff @(posedge clk) begin
        if (rst) hist <= 2'b11;
        else     hist <= {hist[0], data_in};
    end
    // hist[1], hist[0], data_in straddle the nominal sample cycle
    assign rx_bit     = (hist[1] & hist[0]) | (hist[1] & data_in) | (hist[0] & data_in);
    assign start_seen = ~hist[0];
`else
    assign rx_bit     = data_in;
    assign start_seen = ~data_in;
`endif

    assign sample      = (state == START) ? (tick == TICK_HALF) : (tick == TICK_LAST);
    assign par_err_now = (PARITY_MODE == 2) ? ~(par ^ rx_bit) : (par ^ rx_bit);
    assign busy        = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (start_seen) state_next = START;
            START:  if (sample) state_next = rx_bit ? IDLE : DATA;
            DATA:   if (sample && bit_cnt == DATA_LAST)
                        state_next = (PARITY_MODE != 0) ? PARITY : STOP;
            PARITY: if (sample) state_next = STOP;
            STOP:   if (sample && bit_cnt == STOP_LAST) state_next = DONE;
            DONE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick               <= '0;
            bit_cnt            <= '0;
            shift              <= '0;
            par                <= 1'b0;
            fe_acc             <= 1'b0;
            pe_acc             <= 1'b0;
            data_out           <= '0;
            character_received <= 1'b0;
            framing_error      <= 1'b0;
            parity_error       <= 1'b0;
        end else begin
            character_received <= 1'b0;
            if (state == IDLE || state_next != state || sample) tick <= '0;
            else                                                tick <= tick + TW'(1);
            if (state_next != state) bit_cnt <= '0;
            else if (sample)         bit_cnt <= bit_cnt + 4'd1;
            case (state)
                IDLE: begin
                    par    <= 1'b0;
                    fe_acc <= 1'b0;
                    pe_acc <= 1'b0;
                end
                DATA: if (sample) begin
                    shift <= {rx_bit, shift[DATA_BITS-1:1]};
                    par   <= par ^ rx_bit;
                end
                PARITY: if (sample) pe_acc <= par_err_now;
                STOP:   if (sample && !rx_bit) fe_acc <= 1'b1;
                DONE: begin
                    data_out           <= shift;
                    character_received <= 1'b1;
                    framing_error      <= fe_acc;
                    parity_error       <= pe_acc;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - directed bench for uart_rx_param (three parameter sets)
module tb_uart_rx_param;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] line = 3'b111;
    int         cyc = 0;
    int         total = 0;
    int         passed = 0;
    int         failed = 0;
    int         pulses [3] = '{0, 0, 0};
    int         last_pulse [3] = '{0, 0, 0};

    logic [7:0] d0, d1;
    logic [6:0] d2;
    logic [2:0] cr, fe, pe, bz;

    uart_rx_param u0 (.clk(clk), .rst(rst), .data_in(line[0]), .data_out(d0),
        .character_received(cr[0]), .framing_error(fe[0]), .parity_error(pe[0]), .busy(bz[0]));
    uart_rx_param #(.PARITY_MODE(1)) u1 (.clk(clk), .rst(rst), .data_in(line[1]), .data_out(d1),
        .character_received(cr[1]), .framing_error(fe[1]), .parity_error(pe[1]), .busy(bz[1]));
    uart_rx_param #(.DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) u2 (.clk(clk), .rst(rst),
        .data_in(line[2]), .data_out(d2), .character_received(cr[2]), .framing_error(fe[2]),
        .parity_error(pe[2]), .busy(bz[2]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++)
            if (cr[i]) begin
                pulses[i]++;
                last_pulse[i] = cyc;
            end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // start bit, data LSB first, optional parity, stop bits; 16 clocks each
    task automatic send(input int sel, input logic [8:0] d, input int nd, input int np,
                        input logic pbit, input int ns, input logic stopv, output int t0);
        t0 = cyc + 1;
        line[sel] = 1'b0;
        repeat (16) @(negedge clk);
        for (int k = 0; k < nd; k++) begin
            line[sel] = d[k];
            repeat (16) @(negedge clk);
        end
        if (np != 0) begin
            line[sel] = pbit;
            repeat (16) @(negedge clk);
        end
        for (int k = 0; k < ns; k++) begin
            line[sel] = stopv;
            repeat (16) @(negedge clk);
        end
        line[sel] = 1'b1;
    endtask

    logic [7:0] word [4] = '{8'h74, 8'h65, 8'h73, 8'h74};
    int t0, base;

    initial begin
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_data_out", d0, 0);
        check("rst_pulse", cr[0], 0);
        check("rst_fe", fe[0], 0);
        check("rst_pe", pe[0], 0);
        check("rst_busy", bz[0], 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        base = pulses[0];
        send(0, 9'h074, 8, 0, 1'b0, 1, 1'b1, t0);
        check("t1_count", pulses[0] - base, 1);
        check("t1_latency", last_pulse[0] - t0, 153);
        check("t1_data", d0, 8'h74);
        check("t1_fe", fe[0], 0);
        check("t1_pe", pe[0], 0);
        repeat (10) @(negedge clk);

        base = pulses[0];
        for (int i = 0; i < 4; i++) begin
            send(0, {1'b0, word[i]}, 8, 0, 1'b0, 1, 1'b1, t0);
            check("t2_latency", last_pulse[0] - t0, 153);
            check("t2_data", d0, word[i]);
            check("t2_err", {fe[0], pe[0]}, 0);
        end
        check("t2_count", pulses[0] - base, 4);
        repeat (10) @(negedge clk);

        base = pulses[0];
        line[0] = 1'b0;
        repeat (5) @(negedge clk);
        check("t3_busy_mid", bz[0], 1);
        line[0] = 1'b1;
        repeat (4) @(negedge clk);
        check("t3_busy_t0p9", bz[0], 0);
        repeat (200) @(negedge clk);
        check("t3_no_pulse", pulses[0] - base, 0);
        check("t3_data_kept", d0, 8'h74);

        send(0, 9'h055, 8, 0, 1'b0, 1, 1'b0, t0);
        check("t4_latency", last_pulse[0] - t0, 153);
        check("t4_data", d0, 8'h55);
        check("t4_fe", fe[0], 1);
        repeat (30) @(negedge clk);
        send(0, 9'h0A3, 8, 0, 1'b0, 1, 1'b1, t0);
        check("t4_data2", d0, 8'hA3);
        check("t4_fe_clear", fe[0], 0);

        send(1, 9'h007, 8, 1, 1'b1, 1, 1'b1, t0);
        check("t5_even_latency", last_pulse[1] - t0, 169);
        check("t5_even_data", d1, 8'h07);
        check("t5_even_ok", pe[1], 0);
        send(1, 9'h007, 8, 1, 1'b0, 1, 1'b1, t0);
        check("t5_even_bad", pe[1], 1);
        check("t5_even_fe", fe[1], 0);
        send(2, 9'h041, 7, 1, 1'b1, 2, 1'b1, t0);
        check("t5_odd_latency", last_pulse[2] - t0, 169);
        check("t5_odd_data", d2, 7'h41);
        check("t5_odd_pe", pe[2], 0);
        check("t5_odd_fe", fe[2], 0);
        repeat (10) @(negedge clk);

        base = pulses[0];
        line[0] = 1'b0;
        repeat (16) @(negedge clk);
        line[0] = 1'b1;
        repeat (64) @(negedge clk);
        check("t6_busy_before", bz[0], 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_data", d0, 0);
        check("t6_busy", bz[0], 0);
        check("t6_flags", {cr[0], fe[0], pe[0]}, 0);
        repeat (200) @(negedge clk);
        check("t6_no_pulse", pulses[0] - base, 0);
        send(0, 9'h03C, 8, 0, 1'b0, 1, 1'b1, t0);
        check("t6_latency", last_pulse[0] - t0, 153);
        check("t6_data2", d0, 8'h3C);
        check("t6_count", pulses[0] - base, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
